// File: rtl/pdm_cap_pkg.sv
// Shared types and defaults for the PDM capture sequencer.
package pdm_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_WAIT_FALL = 3'd3,
        ST_READ      = 3'd4,
        ST_PUSH      = 3'd5,
        ST_GAP       = 3'd6
    } pdm_cap_state_e;

    localparam logic [31:0] PDM_CAP_BASE_ADDR = 32'h8000_0000;
    localparam int unsigned PDM_CAP_WORDS     = 64;

endpackage

// File: rtl/pdm_cap_timer.sv
// Loadable up/down counter shared by the inter-frame gap and the busy-wait timeout.
module pdm_cap_timer #(
    parameter int unsigned W = 16
) (
    input  logic         g_hclk_es1,
    input  logic         hreset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] cnt
);

    always_ff @(posedge g_hclk_es1) begin
        if (hreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= up ? cnt + W'(1) : cnt - W'(1);
        end
    end

endmodule

// File: rtl/pdm_cap_seq.sv
// Capture sequencer: triggers pdm_m, waits out its busy cycle, streams one frame per trigger.
// Optional busy-wait timeout is built when PDM_CAP_TIMEOUT_EN is defined.
module pdm_cap_seq
    import pdm_cap_pkg::*;
#(
    parameter int unsigned WORDS     = PDM_CAP_WORDS,
    parameter logic [31:0] BASE_ADDR = PDM_CAP_BASE_ADDR,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic        g_hclk_es1,
    input  logic        hreset,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic [7:0]  cfg_frames,
    input  logic [15:0] cfg_gap,
    output logic        cap_ctrl,
    input  logic        cap_bsy,
    output logic [31:0] cap_addr,
    input  logic [31:0] cap_dout,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned CNT_W    = (TIMEOUT_W > 16) ? TIMEOUT_W : 16;
    localparam logic [7:0]  LAST_IDX = 8'(WORDS - 1);

    pdm_cap_state_e state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  frames_q;
    logic [15:0] gap_q;
    logic        stop_pend;
    logic        start_acc, frame_end, run_ends, to_hit;
    logic        tmr_load, tmr_en, tmr_up;
    logic [CNT_W-1:0] tmr_val, tmr_cnt;

    pdm_cap_timer #(.W(CNT_W)) u_timer (
        .g_hclk_es1 (g_hclk_es1),
        .hreset     (hreset),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .en         (tmr_en),
        .up         (tmr_up),
        .cnt        (tmr_cnt)
    );

`ifdef PDM_CAP_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_next;
    // Fires on the edge where the count would reach 2^TIMEOUT_W-1.
    assign to_next = tmr_cnt[TIMEOUT_W-1:0] + TIMEOUT_W'(1);
    assign to_hit  = &to_next;
`else
    assign to_hit  = 1'b0;
`endif

    assign run_ends = ((frames_q != 8'd0) && (frame_cnt + 8'd1 == frames_q)) || stop_pend || cfg_stop;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_acc = 1'b0;
        frame_end = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        tmr_up    = 1'b0;
        unique case (state_q)
            ST_IDLE: if (cfg_start && !cfg_stop) begin
                state_d   = ST_ARM;
                start_acc = 1'b1;
            end
            ST_ARM: state_d = cfg_stop ? ST_IDLE : ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                if (cfg_stop || to_hit) state_d = ST_IDLE;
                else if (cap_bsy)       state_d = ST_WAIT_FALL;
            end
            ST_WAIT_FALL: begin
                if (cfg_stop || to_hit) state_d = ST_IDLE;
                else if (!cap_bsy) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                end
            end
            ST_READ: state_d = ST_PUSH;
            ST_PUSH: if (out_valid && out_ready) begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_READ;
                end else begin
                    frame_end = 1'b1;
                    state_d   = run_ends ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (cfg_stop)                     state_d = ST_IDLE;
                else if (tmr_cnt[15:0] == 16'd0)  state_d = ST_ARM;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ARM) begin
            tmr_load = 1'b1;
        end else if (state_d == ST_GAP && state_q != ST_GAP) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(gap_q);
        end else if (state_q == ST_GAP) begin
            tmr_en = 1'b1;
        end
`ifdef PDM_CAP_TIMEOUT_EN
        else if (state_q == ST_ARM || state_q == ST_WAIT_RISE || state_q == ST_WAIT_FALL) begin
            tmr_en = 1'b1;
            tmr_up = 1'b1;
        end
`endif
    end

    always_ff @(posedge g_hclk_es1) begin
        if (hreset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            frames_q  <= '0;
            gap_q     <= '0;
            stop_pend <= 1'b0;
            cap_ctrl  <= 1'b0;
            cap_addr  <= BASE_ADDR;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_ctrl  <= (state_d == ST_ARM);
            out_valid <= (state_d == ST_PUSH);
            busy      <= (state_d != ST_IDLE);
            done      <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
            if (start_acc) begin
                frames_q  <= cfg_frames;
                gap_q     <= cfg_gap;
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (state_d == ST_IDLE)
                stop_pend <= 1'b0;
            else if ((state_q == ST_READ || state_q == ST_PUSH) && cfg_stop)
                stop_pend <= 1'b1;
            if (state_d == ST_READ)
                cap_addr <= BASE_ADDR + {22'd0, idx_d, 2'b00};
            // pdm_m data for cap_addr is sampled on the edge that leaves READ.
            if (state_q == ST_READ)
                out_data <= cap_dout;
        end
    end

`ifdef PDM_CAP_TIMEOUT_EN
    always_ff @(posedge g_hclk_es1) begin
        if (hreset)
            err_timeout <= 1'b0;
        else if (start_acc)
            err_timeout <= 1'b0;
        else if ((state_q == ST_WAIT_RISE || state_q == ST_WAIT_FALL) && !cfg_stop && to_hit)
            err_timeout <= 1'b1;
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_cap_seq.sv
// Scoreboard bench for pdm_cap_seq with WORDS=4 and a 4-bit timeout counter.
module tb_pdm_cap_seq;

    logic        clk = 1'b0;
    logic        hreset = 1'b1;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0;
    logic [7:0]  cfg_frames = 8'd0;
    logic [15:0] cfg_gap = 16'd0;
    logic        cap_ctrl, cap_bsy, out_valid, out_ready = 1'b1;
    logic        busy, done, err_timeout;
    logic [31:0] cap_addr, cap_dout, out_data;
    logic [7:0]  frame_cnt;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int bsy_len = 10, bsy_cnt = 0;
    logic bsy_stuck = 1'b0;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } exp_t;
    exp_t sb[$];
    int ctrl_cyc[$], hs_cyc[$], fall_cyc[$], vrise_cyc[$];
    int n_done = 0, done_cyc = 0, done_fc = 0;
    logic done_err = 1'b0;
    logic prev_bsy = 1'b0, prev_valid = 1'b0, stall_prev = 1'b0;
    logic [31:0] stall_data = '0, stall_addr = '0;

    logic [31:0] exp_addr_t [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    logic [31:0] exp_data_t [4] = '{32'h0000_FFFF, 32'h0004_FFFB, 32'h0008_FFF7, 32'h000C_FFF3};

    pdm_cap_seq #(.WORDS(4), .BASE_ADDR(32'h8000_0000), .TIMEOUT_W(4)) dut (
        .g_hclk_es1 (clk),
        .hreset     (hreset),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_frames (cfg_frames),
        .cfg_gap    (cfg_gap),
        .cap_ctrl   (cap_ctrl),
        .cap_bsy    (cap_bsy),
        .cap_addr   (cap_addr),
        .cap_dout   (cap_dout),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // pdm_m stand-in: busy for bsy_len cycles after each trigger, data derived from address
    always @(posedge clk) begin
        if (cap_ctrl && !bsy_stuck) bsy_cnt <= bsy_len;
        else if (bsy_cnt != 0)      bsy_cnt <= bsy_cnt - 1;
    end
    assign cap_bsy  = (bsy_cnt != 0);
    assign cap_dout = {cap_addr[15:0], ~cap_addr[15:0]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1000;
    endfunction

    // monitor: pops the scoreboard on each handshake, checks hold stability during stalls
    always @(negedge clk) begin
        if (!hreset) begin
            if (out_valid && stall_prev) begin
                chk("stall_data_stable", out_data, stall_data);
                chk("stall_addr_stable", cap_addr, stall_addr);
            end
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got 0x%08h at addr 0x%08h, expected none", out_data, cap_addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word_data", out_data, e.data);
                    chk("word_addr", cap_addr, e.addr);
                end
            end
            if (cap_ctrl) ctrl_cyc.push_back(cyc);
            if (prev_bsy && !cap_bsy) fall_cyc.push_back(cyc);
            if (out_valid && !prev_valid) vrise_cyc.push_back(cyc);
            if (done) begin
                n_done++;
                done_cyc = cyc;
                done_fc  = frame_cnt;
                done_err = err_timeout;
            end
        end
        stall_prev = out_valid && !out_ready && !hreset;
        stall_data = out_data;
        stall_addr = cap_addr;
        prev_bsy   = cap_bsy;
        prev_valid = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int i = 0; i < 4; i++)
                sb.push_back('{addr: exp_addr_t[i], data: exp_data_t[i]});
    endtask

    task automatic start_pulse(output int st);
        st = cyc;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done;
        int k = 0;
        while (n_done == d0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_within_budget", 32'(n_done != d0), 32'd1);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int k = 0;
        while (hs_cyc.size() < target && k < budget) begin
            tick();
            k++;
        end
        chk("handshake_within_budget", 32'(hs_cyc.size() >= target), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, c0, h0, f0, v0, d0;
        repeat (3) tick();
        chk("rst_cap_ctrl", 32'(cap_ctrl), 32'd0);
        chk("rst_cap_addr", cap_addr, 32'h8000_0000);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        hreset = 1'b0;
        tick();

        // single frame, ready always high
        c0 = ctrl_cyc.size(); h0 = hs_cyc.size(); f0 = fall_cyc.size(); v0 = vrise_cyc.size();
        cfg_frames = 8'd1; cfg_gap = 16'd0; bsy_len = 10;
        push_frames(1);
        start_pulse(st);
        wait_done(200);
        chk("t1_ctrl_pulses", 32'(ctrl_cyc.size() - c0), 32'd1);
        chk("t1_start_to_ctrl", 32'(qat(ctrl_cyc, c0) - st), 32'd1);
        chk("t1_bsyfall_to_valid", 32'(qat(vrise_cyc, v0) - qat(fall_cyc, f0)), 32'd2);
        chk("t1_throughput", 32'(qat(hs_cyc, h0 + 3) - qat(hs_cyc, h0)), 32'd6);
        chk("t1_done_latency", 32'(done_cyc - qat(hs_cyc, h0 + 3)), 32'd1);
        chk("t1_frame_cnt", 32'(done_fc), 32'd1);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // three frames with a 5-cycle gap
        c0 = ctrl_cyc.size(); h0 = hs_cyc.size();
        cfg_frames = 8'd3; cfg_gap = 16'd5; bsy_len = 3;
        push_frames(3);
        start_pulse(st);
        wait_done(400);
        chk("t2_ctrl_pulses", 32'(ctrl_cyc.size() - c0), 32'd3);
        chk("t2_gap_f1", 32'(qat(ctrl_cyc, c0 + 1) - qat(hs_cyc, h0 + 3)), 32'd7);
        chk("t2_gap_f2", 32'(qat(ctrl_cyc, c0 + 2) - qat(hs_cyc, h0 + 7)), 32'd7);
        chk("t2_frame_cnt", 32'(done_fc), 32'd3);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 20-cycle back-pressure mid-frame
        h0 = hs_cyc.size();
        cfg_frames = 8'd1; cfg_gap = 16'd0; bsy_len = 4;
        push_frames(1);
        start_pulse(st);
        wait_hs(h0 + 2, 100);
        out_ready = 1'b0;
        repeat (20) tick();
        chk("t3_held_valid", 32'(out_valid), 32'd1);
        chk("t3_no_consume", 32'(hs_cyc.size() - h0), 32'd2);
        out_ready = 1'b1;
        wait_done(100);
        chk("t3_frame_cnt", 32'(done_fc), 32'd1);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // stop during PUSH of word 1 in continuous mode
        c0 = ctrl_cyc.size(); h0 = hs_cyc.size();
        cfg_frames = 8'd0; cfg_gap = 16'd2; bsy_len = 3;
        push_frames(1);
        start_pulse(st);
        wait_hs(h0 + 1, 100);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("t4_word1_valid", 32'(out_valid), 32'd1);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        wait_done(100);
        chk("t4_frame_cnt", 32'(done_fc), 32'd1);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        repeat (30) tick();
        chk("t4_ctrl_pulses", 32'(ctrl_cyc.size() - c0), 32'd1);
        chk("t4_idle_busy", 32'(busy), 32'd0);

`ifdef PDM_CAP_TIMEOUT_EN
        // busy never rises: timeout after 15 cycles
        c0 = ctrl_cyc.size();
        cfg_frames = 8'd1; cfg_gap = 16'd0; bsy_stuck = 1'b1;
        start_pulse(st);
        wait_done(100);
        chk("t5_timeout_latency", 32'(done_cyc - qat(ctrl_cyc, c0)), 32'd15);
        chk("t5_err_at_done", 32'(done_err), 32'd1);
        chk("t5_err_sticky", 32'(err_timeout), 32'd1);
        chk("t5_frame_cnt", 32'(done_fc), 32'd0);
        bsy_stuck = 1'b0; bsy_len = 3;
        push_frames(1);
        start_pulse(st);
        chk("t5_err_cleared", 32'(err_timeout), 32'd0);
        wait_done(100);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
`endif

        // reset while waiting for busy to fall
        c0 = ctrl_cyc.size();
        cfg_frames = 8'd1; bsy_len = 10;
        start_pulse(st);
        repeat (3) tick();
        hreset = 1'b1;
        tick();
        chk("t6_cap_ctrl", 32'(cap_ctrl), 32'd0);
        chk("t6_cap_addr", cap_addr, 32'h8000_0000);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_data", out_data, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_err", 32'(err_timeout), 32'd0);
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        hreset = 1'b0;
        repeat (15) tick();
        chk("t6_stays_idle", 32'(busy), 32'd0);
        chk("t6_ctrl_pulses", 32'(ctrl_cyc.size() - c0), 32'd1);

        // start and stop together in IDLE
        c0 = ctrl_cyc.size(); d0 = n_done;
        cfg_start = 1'b1; cfg_stop = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_stop = 1'b0;
        repeat (10) tick();
        chk("t7_no_ctrl", 32'(ctrl_cyc.size() - c0), 32'd0);
        chk("t7_no_busy", 32'(busy), 32'd0);
        chk("t7_no_done", 32'(n_done - d0), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
